// File: rtl/stoch_sum_mat_pkg.sv
// stoch_sum_mat_pkg: shared stochastic-arithmetic limits and widths.
package stoch_sum_mat_pkg;
  function automatic int cnt_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int cnt_min(input int w);
    return -(1 << (w - 1));
  endfunction
  // Wide enough that C plus n signed unit terms never wraps before clamping.
  function automatic int sum_width(input int n, input int w);
    return w + $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/stoch_sum.sv
// stoch_sum: one element of the clamped stochastic adder with signed remainder counter.
module stoch_sum
  import stoch_sum_mat_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic [NUM_INPUTS-1:0] NEG,
  input  logic [NUM_INPUTS-1:0] x,
  output logic                  y,
  output logic                  ovf
);
  localparam int TW = sum_width(NUM_INPUTS, CNT_WIDTH);
  localparam logic signed [TW-1:0] MAXV = TW'(cnt_max(CNT_WIDTH));
  localparam logic signed [TW-1:0] MINV = TW'(cnt_min(CNT_WIDTH));
  localparam logic signed [TW-1:0] ONE  = TW'(1);
  logic signed [CNT_WIDTH-1:0] c_q, c_d;
  logic signed [TW-1:0] t, u;
  logic y_q, y_d, ovf_q, sat;
  always_comb begin
    t = TW'(c_q);
    for (int k = 0; k < NUM_INPUTS; k++) t = NEG[k] ? t - TW'(x[k]) : t + TW'(x[k]);
    y_d = t >= ONE;
    u   = y_d ? t - ONE : t;
    sat = (u > MAXV) || (u < MINV);
    c_d = u > MAXV ? CNT_WIDTH'(MAXV) : u < MINV ? CNT_WIDTH'(MINV) : CNT_WIDTH'(u);
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c_q   <= '0;
      y_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (CLR) begin
      c_q   <= '0;
      y_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      y_q <= EN & y_d;
      if (EN) begin
        c_q   <= c_d;
        ovf_q <= ovf_q | sat;
      end
    end
  end
  assign y   = y_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/stoch_sum_mat.sv
// stoch_sum_mat: element-wise clamped stochastic sum of NUM_INPUTS bitstream matrices.
module stoch_sum_mat
  import stoch_sum_mat_pkg::*;
#(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_COLS   = 2,
  parameter int NUM_INPUTS = 2,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  logic                                      EN,
  input  logic                                      CLR,
  input  logic [NUM_INPUTS-1:0]                     NEG,
  input  logic [NUM_INPUTS*NUM_ROWS*NUM_COLS-1:0]   X,
  output logic [NUM_ROWS*NUM_COLS-1:0]              Y,
  output logic [NUM_ROWS*NUM_COLS-1:0]              OVF
);
  localparam int NE = NUM_ROWS * NUM_COLS;
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
      logic [NUM_INPUTS-1:0] xe;
      for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_op
        assign xe[k] = X[k*NE + i*NUM_COLS + j];
      end
      stoch_sum #(.NUM_INPUTS(NUM_INPUTS), .CNT_WIDTH(CNT_WIDTH)) u_el (
        .CLK (CLK),
        .nRST(nRST),
        .EN  (EN),
        .CLR (CLR),
        .NEG (NEG),
        .x   (xe),
        .y   (Y[i*NUM_COLS + j]),
        .ovf (OVF[i*NUM_COLS + j])
      );
    end
  end
endmodule

// File: tb/tb_stoch_sum_mat.sv
// tb_stoch_sum_mat: directed vectors with a queued scoreboard checked once per cycle.
module tb_stoch_sum_mat;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       EN = 1'b0;
  logic       CLR = 1'b0;
  logic [1:0] NEG = 2'b00;
  logic [7:0] X = 8'h00;
  logic [3:0] Y, OVF;
  typedef struct {
    int         id;
    logic [3:0] y;
    logic [3:0] ovf;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int step_id = 0;
  stoch_sum_mat dut (
    .CLK (CLK),
    .nRST(nRST),
    .EN  (EN),
    .CLR (CLR),
    .NEG (NEG),
    .X   (X),
    .Y   (Y),
    .OVF (OVF)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (Y !== e.y || OVF !== e.ovf) begin
        errors++;
        $display("FAIL step%0d: Y=%b OVF=%b expected Y=%b OVF=%b", e.id, Y, OVF, e.y, e.ovf);
      end
    end
  end
  // a/b are operand A and B element nibbles (row-major); expectation is for the next edge.
  task automatic step(input logic en, input logic clr, input logic [1:0] neg,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ey, input logic [3:0] eovf);
    exp_t e;
    @(negedge CLK);
    EN = en;
    CLR = clr;
    NEG = neg;
    X = {b, a};
    e.id = step_id;
    e.y = ey;
    e.ovf = eovf;
    q.push_back(e);
    step_id++;
  endtask
  task automatic direct(input string name, input logic [3:0] ey, input logic [3:0] eovf);
    checks++;
    if (Y !== ey || OVF !== eovf) begin
      errors++;
      $display("FAIL %s: Y=%b OVF=%b expected Y=%b OVF=%b", name, Y, OVF, ey, eovf);
    end
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    direct("reset", 4'h0, 4'h0);
    nRST = 1'b1;
    // single operand of ones: Y=1 every cycle, C stays 0
    for (int i = 0; i < 8; i++) step(1, 0, 2'b00, 4'hF, 4'h0, 4'hF, 4'h0);
    // both operands 1: C climbs to 7, saturates on cycle 8
    for (int i = 0; i < 7; i++) step(1, 0, 2'b00, 4'hF, 4'hF, 4'hF, 4'h0);
    step(1, 0, 2'b00, 4'hF, 4'hF, 4'hF, 4'hF);
    step(1, 0, 2'b00, 4'hF, 4'hF, 4'hF, 4'hF);
    step(0, 1, 2'b00, 4'hF, 4'hF, 4'h0, 4'h0);
    // B subtracted: debt of 3 is repaid before a 1 is emitted
    for (int i = 0; i < 3; i++) step(1, 0, 2'b10, 4'h0, 4'hF, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 2'b10, 4'hF, 4'h0, 4'h0, 4'h0);
    step(1, 0, 2'b10, 4'hF, 4'h0, 4'hF, 4'h0);
    // only element (1,0) driven, EN toggled
    step(1, 0, 2'b00, 4'b0100, 4'h0, 4'b0100, 4'h0);
    step(0, 0, 2'b00, 4'b0100, 4'h0, 4'h0, 4'h0);
    step(1, 0, 2'b00, 4'b0100, 4'h0, 4'b0100, 4'h0);
    // negative saturation at -8 on cycle 9, debt retained: 8 ones to repay
    for (int i = 0; i < 8; i++) step(1, 0, 2'b10, 4'h0, 4'hF, 4'h0, 4'h0);
    step(1, 0, 2'b10, 4'h0, 4'hF, 4'h0, 4'hF);
    for (int i = 0; i < 8; i++) step(1, 0, 2'b10, 4'hF, 4'h0, 4'h0, 4'hF);
    step(1, 0, 2'b10, 4'hF, 4'h0, 4'hF, 4'hF);
    step(0, 0, 2'b00, 4'hF, 4'hF, 4'h0, 4'hF);
    step(0, 1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0);
    // build C=5, then CLR with EN and inputs high wins
    for (int i = 0; i < 5; i++) step(1, 0, 2'b00, 4'hF, 4'hF, 4'hF, 4'h0);
    step(1, 1, 2'b00, 4'hF, 4'hF, 4'h0, 4'h0);
    step(1, 0, 2'b10, 4'h0, 4'hF, 4'h0, 4'h0);
    step(0, 1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0);
    // per-element patterns and NEG change mid-stream
    step(1, 0, 2'b00, 4'b0011, 4'b0101, 4'b0111, 4'h0);
    step(1, 0, 2'b00, 4'b0011, 4'b0101, 4'b0111, 4'h0);
    step(1, 0, 2'b01, 4'b0011, 4'b0101, 4'b0101, 4'h0);
    step(0, 1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0);
    // saturate high, then async reset between edges
    for (int i = 0; i < 7; i++) step(1, 0, 2'b00, 4'hF, 4'hF, 4'hF, 4'h0);
    step(1, 0, 2'b00, 4'hF, 4'hF, 4'hF, 4'hF);
    @(negedge CLK);
    EN = 1'b0;
    #2 nRST = 1'b0;
    #1 direct("async_reset", 4'h0, 4'h0);
    @(negedge CLK);
    nRST = 1'b1;
    // C must restart from 0, not 7
    step(1, 0, 2'b10, 4'h0, 4'hF, 4'h0, 4'h0);
    step(1, 0, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0);
    step(1, 0, 2'b00, 4'hF, 4'h0, 4'hF, 4'h0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stoch_sum_mat.md
STOCH_SUM_MAT -- requirements
Module: stoch_sum_mat

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 2: matrix rows.
REQ-002 SHALL have parameter NUM_COLS, default 2: matrix columns.
REQ-003 SHALL have parameter NUM_INPUTS, default 2 (range 2..8): operand matrices summed.
REQ-004 SHALL have parameter CNT_WIDTH, default 4 (min 3): signed per-element remainder counter width.
REQ-005 SHALL have port CLK  input  1: sole clock, rising edge.
REQ-006 SHALL have port nRST  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port EN  input  1: advance all element counters this cycle.
REQ-008 SHALL have port CLR  input  1: synchronous clear of counters, Y and OVF.
REQ-009 SHALL have port NEG  input  NUM_INPUTS: bit k set means operand k is subtracted.
REQ-010 SHALL have port X  input  NUM_INPUTS*NUM_ROWS*NUM_COLS: operand bitstreams, operand-major, row-major within operand; element (k,i,j) at bit k*NUM_ROWS*NUM_COLS + i*NUM_COLS + j.
REQ-011 SHALL have port Y  output  NUM_ROWS*NUM_COLS: registered sum bitstream, row-major.
REQ-012 SHALL have port OVF  output  NUM_ROWS*NUM_COLS: sticky per-element counter-saturation flag.

Function
REQ-013 Each element SHALL keep a signed remainder counter C (CNT_WIDTH bits), range [-2^(CNT_WIDTH-1), 2^(CNT_WIDTH-1)-1].
REQ-014 When EN=1 and CLR=0, per element: S = sum over k of (NEG[k] ? -x_k : +x_k); T = C + S computed at CNT_WIDTH+log2(NUM_INPUTS)+1 bits, no intermediate wrap.
REQ-015 If T >= 1: Y bit = 1, C <= T-1; else Y bit = 0, C <= T.
REQ-016 C SHALL saturate to its range on the update in REQ-015 and SHALL never wrap; saturating sets that element's OVF bit.
REQ-017 Y SHALL be registered: result of inputs sampled at edge n appears after edge n, latency exactly 1 cycle.
REQ-018 When EN=0 and CLR=0: C and OVF hold; Y drives 0 on the next edge.
REQ-019 CLR=1 SHALL on the next edge set all C, Y and OVF to 0 regardless of EN; CLR wins over simultaneous EN.
REQ-020 OVF bits SHALL stay set until CLR or reset; a saturating cycle still emits its Y bit per REQ-015.
REQ-021 NEG SHALL be sampled every enabled cycle; changing it mid-stream SHALL take effect on that cycle with no flush.
REQ-022 Output value SHALL equal the clamped sum min(1, max(0, sum)) in long-run mean; negative excess is retained in C as debt, not discarded, until saturation.
REQ-023 All elements SHALL be independent; no cross-element state.

Reset
REQ-024 nRST low SHALL asynchronously force every C, Y and OVF bit to 0.
REQ-025 Reset asserted mid-stream SHALL discard all remainders; first enabled edge after release SHALL behave as from C=0.
REQ-026 Deassertion SHALL be applied synchronously to CLK by the integrating top level; the block itself uses nRST directly.

Structure
REQ-027 Counter limits (CNT_MAX, CNT_MIN) and the S-width computation SHALL live in the shared stochastic definitions header, not in this module.
REQ-028 One sub-module stoch_sum SHALL implement a single element (ports CLK, nRST, EN, CLR, NEG, x, y, ovf); stoch_sum_mat SHALL instantiate it NUM_ROWS*NUM_COLS times via generate over row/col.
REQ-029 No combinational path from any input to Y or OVF.

Verification
REQ-030 Defaults, EN=1, NEG=0, all A bits 1, all B bits 0 for 8 cycles -> Y all 1 from cycle 1, C stays 0, OVF 0.
REQ-031 NUM_INPUTS=2, NEG=0, both operands 1 every cycle -> Y=1 each cycle, C rises by 1 per cycle, saturates at 7 on cycle 7, OVF sets on cycle 8, Y stays 1.
REQ-032 NEG=2'b10, A=0, B=1 for 3 cycles then A=1, B=0 for 4 cycles -> Y=0 for 3 cycles, C=-3; then Y=0,0,0,1 with C returning -2,-1,0,0.
REQ-033 Element (1,0) driven, others idle, EN toggled 1,0,1 -> Y follows only on enabled cycles, Y=0 on disabled cycle, C held, other elements Y=0.
REQ-034 Mid-stream with C=5, assert CLR together with EN and inputs 1 -> next cycle Y=0, C=0, OVF=0; then assert nRST low between edges -> Y and OVF drop to 0 immediately, before next edge.
